// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Carries the request side (req/we/addr/wdata/be) and the response side (rvalid/rdata).
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output rvalid, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// Memory-stage load/store unit and MEM/WB pipeline register.
// Issues data-memory accesses, aligns load data and stalls upstream while an access is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               RegWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic               MemWriteM,
  input  logic               MemReadM,
  input  logic [2:0]         Funct3M,
  input  logic [31:0]        ALUResultM,
  input  logic [31:0]        WriteDataM,
  input  logic [4:0]         RdM,
  input  logic [31:0]        PCPlus4M,
  mem_access_stage_if.master dmem,
  output logic               StallM,
  output logic               MisalignErr,
  output logic               BusErr,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic [31:0]        ALUResultW,
  output logic [31:0]        RdataW,
  output logic [4:0]         RdW,
  output logic [31:0]        PCPlus4W
);
  // state | meaning
  // IDLE  | nothing outstanding; an aligned M-stage access is issued combinationally
  // BUSY  | request held on the bus, waiting for rvalid or the timeout
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mem_op;
  logic             w_store;
  logic             w_misalign;
  logic             w_timeout;
  logic             w_req;
  logic             w_capture;
  logic [1:0]       w_a;
  logic [1:0]       w_size;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_load_data;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  // A simultaneous read and write is treated as a load.
  assign w_mem_op   = MemReadM | MemWriteM;
  assign w_store    = MemWriteM & ~MemReadM;
  assign w_a        = ALUResultM[1:0];
  assign w_size     = Funct3M[1:0];
  assign w_misalign = w_mem_op & (((w_size == 2'b01) & w_a[0]) |
                                  (w_size[1] & (w_a != 2'b00)));
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    StallM      = 1'b0;
    MisalignErr = 1'b0;
    BusErr      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_mem_op) begin
          w_capture = 1'b1;
        end else if (w_misalign) begin
          MisalignErr = 1'b1;
        end else begin
          w_req = 1'b1;
          if (dmem.rvalid) begin
            w_capture = 1'b1;
          end else begin
            StallM = 1'b1;
            w_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (dmem.rvalid) begin
          w_req     = 1'b1;
          w_capture = 1'b1;
          w_next    = S_IDLE;
        end else if (w_timeout) begin
          BusErr = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_req  = 1'b1;
          StallM = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Keep the bus and pipeline quiet while reset is held.
    if (reset) begin
      w_req       = 1'b0;
      StallM      = 1'b0;
      MisalignErr = 1'b0;
      BusErr      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_BUSY && w_next == S_BUSY) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    if (w_store) begin
      case (w_size)
        2'b00: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << w_a;
          w_wdata = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign dmem.req   = w_req;
  assign dmem.we    = w_req & w_store;
  assign dmem.addr  = {ALUResultM[31:2], 2'b00};
  assign dmem.wdata = w_wdata;
  assign dmem.be    = w_be;

  always_comb begin
    w_byte = dmem.rdata[8*w_a +: 8];
    w_half = w_a[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (w_size)
      2'b00:   w_load_data = Funct3M[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = Funct3M[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = dmem.rdata;
    endcase
  end

  // Stalled, misaligned and timed-out cycles all hand writeback an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || !w_capture) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= 32'h0;
      RdataW     <= 32'h0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'h0;
    end else begin
      RegWriteW  <= RegWriteM & (RdM != 5'd0);
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      RdataW     <= MemReadM ? w_load_data : 32'h0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, hand sequences
// for wait/timeout/reset corners, and randomized ops checked against a reference model.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        RegWriteM, MemWriteM, MemReadM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM, MisalignErr, BusErr;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, RdataW, PCPlus4W;
  logic [4:0]  RdW;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .MemReadM(MemReadM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .dmem(bus),
    .StallM(StallM), .MisalignErr(MisalignErr), .BusErr(BusErr),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .RdataW(RdataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  typedef struct packed {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic        regw;
    logic [3:0]  waits;
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdw;
    logic        mis;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic op_t mkop(input logic r, input logic w, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdata, input logic [1:0] rsrc,
                               input logic [4:0] rd, input logic regw, input logic [3:0] waits);
    op_t o;
    o.rd_en = r;  o.wr_en = w;  o.f3 = f3;  o.addr = addr;  o.wd = wd;
    o.rdata = rdata;  o.rsrc = rsrc;  o.rd = rd;  o.regw = regw;  o.waits = waits;
    return o;
  endfunction

  // Reference model: lane/extension rules computed with plain arithmetic.
  function automatic void model(input op_t o, output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] rdw, output logic mis);
    int a, sz;
    logic [31:0] v;
    a   = int'(o.addr % 32'd4);
    sz  = int'(o.f3) % 4;
    mis = (o.rd_en || o.wr_en) && ((sz == 1 && (a % 2) != 0) || (sz >= 2 && a != 0));
    be  = 4'hF;
    wd  = o.wd;
    if (o.wr_en && !o.rd_en) begin
      if (sz == 0) begin
        be = 4'(1 << a);
        wd = (o.wd % 32'd256) * 32'h01010101;
      end else if (sz == 1) begin
        be = 4'(3 << a);
        wd = (o.wd % 32'd65536) * 32'h00010001;
      end
    end
    rdw = 32'h0;
    if (o.rd_en) begin
      if (sz == 0) begin
        v = (o.rdata / (32'd1 << (8 * a))) % 32'd256;
        if (o.f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 1) begin
        v = (o.rdata / (32'd1 << (16 * (a / 2)))) % 32'd65536;
        if (o.f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = o.rdata;
      end
      rdw = v;
    end
  endfunction

  task automatic drive(input op_t o, input logic [31:0] pc);
    MemReadM   = o.rd_en;
    MemWriteM  = o.wr_en;
    Funct3M    = o.f3;
    ALUResultM = o.addr;
    WriteDataM = o.wd;
    ResultSrcM = o.rsrc;
    RdM        = o.rd;
    RegWriteM  = o.regw;
    PCPlus4M   = pc;
    bus.rdata  = o.rdata;
  endtask

  // Called at posedge+1; returns at posedge+1 after the op has been captured into W.
  task automatic run_op(input string nm, input op_t o, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] erd, input logic emis);
    logic        memop;
    logic [31:0] pc;
    int          cyc;
    bit          done;
    memop = o.rd_en | o.wr_en;
    pc    = $urandom;
    drive(o, pc);
    cyc  = 0;
    done = 0;
    while (!done) begin
      bus.rvalid = memop && !emis && (cyc == int'(o.waits));
      @(negedge clk);
      chk({nm, " buserr"}, BusErr, 0);
      if (!memop || emis) begin
        chk({nm, " misalign"}, MisalignErr, emis);
        chk({nm, " req"}, bus.req, 0);
        chk({nm, " stall"}, StallM, 0);
        done = 1;
      end else begin
        chk({nm, " misalign"}, MisalignErr, 0);
        chk({nm, " req"}, bus.req, 1);
        chk({nm, " addr"}, bus.addr, {o.addr[31:2], 2'b00});
        chk({nm, " be"}, bus.be, ebe);
        chk({nm, " we"}, bus.we, o.wr_en & ~o.rd_en);
        if (o.wr_en && !o.rd_en) chk({nm, " wdata"}, bus.wdata, ewd);
        chk({nm, " stall"}, StallM, cyc < int'(o.waits));
        if (cyc >= int'(o.waits)) done = 1;
        else if (cyc > TO + 2) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s bound: no completion after %0d cycles, required by cycle %0d", nm, cyc, o.waits);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.rvalid = 1'b0;
    chk({nm, " RegWriteW"}, RegWriteW, emis ? 1'b0 : (o.regw && o.rd != 5'd0));
    if (!emis) begin
      chk({nm, " RdW"}, RdW, o.rd);
      chk({nm, " ResultSrcW"}, ResultSrcW, o.rsrc);
      chk({nm, " ALUResultW"}, ALUResultW, o.addr);
      chk({nm, " PCPlus4W"}, PCPlus4W, pc);
      chk({nm, " RdataW"}, RdataW, erd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required end before 200000 ns");
    $fatal(1);
  end

  vec_t        vt[15];
  op_t         o;
  logic [3:0]  mbe;
  logic [31:0] mwd, mrd;
  logic        mmis;
  int          kind, tmp;

  initial begin
    vt[0]  = '{mkop(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2'b01, 5'd5, 1, 4'd0), 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[1]  = '{mkop(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 2'b01, 5'd6, 1, 4'd3), 4'hF, 32'h0, 32'hFFFFFF80, 1'b0};
    vt[2]  = '{mkop(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2'b01, 5'd6, 1, 4'd3), 4'hF, 32'h0, 32'h00000080, 1'b0};
    vt[3]  = '{mkop(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2'b00, 5'd0, 0, 4'd1), 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
    vt[4]  = '{mkop(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 2'b01, 5'd7, 1, 4'd0), 4'hF, 32'h0, 32'h0, 1'b1};
    vt[5]  = '{mkop(1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 2'b01, 5'd8, 1, 4'd2), 4'hF, 32'h0, 32'hFFFF8001, 1'b0};
    vt[6]  = '{mkop(1, 0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 2'b01, 5'd9, 1, 4'd0), 4'hF, 32'h0, 32'h0000F00D, 1'b0};
    vt[7]  = '{mkop(0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 2'b00, 5'd0, 0, 4'd0), 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0};
    vt[8]  = '{mkop(0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 2'b00, 5'd0, 0, 4'd2), 4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
    vt[9]  = '{mkop(1, 0, 3'b001, 32'h203, 32'h0, 32'h0, 2'b01, 5'd10, 1, 4'd0), 4'hF, 32'h0, 32'h0, 1'b1};
    vt[10] = '{mkop(0, 0, 3'b000, 32'h12345678, 32'h0, 32'h0, 2'b00, 5'd7, 1, 4'd0), 4'hF, 32'h0, 32'h0, 1'b0};
    vt[11] = '{mkop(1, 0, 3'b010, 32'h500, 32'h0, 32'h11111111, 2'b01, 5'd0, 1, 4'd1), 4'hF, 32'h0, 32'h11111111, 1'b0};
    vt[12] = '{mkop(1, 1, 3'b010, 32'h600, 32'h99999999, 32'h0BADF00D, 2'b01, 5'd11, 1, 4'd0), 4'hF, 32'h0, 32'h0BADF00D, 1'b0};
    vt[13] = '{mkop(0, 0, 3'b000, 32'h00000ABC, 32'h0, 32'h0, 2'b10, 5'd1, 1, 4'd0), 4'hF, 32'h0, 32'h0, 1'b0};
    vt[14] = '{mkop(0, 1, 3'b000, 32'h003, 32'h00000012, 32'h0, 2'b00, 5'd0, 0, 4'd4), 4'b1000, 32'h12121212, 32'h0, 1'b0};

    reset      = 1'b1;
    bus.rvalid = 1'b0;
    drive(mkop(0, 0, 3'b0, 32'h0, 32'h0, 32'h0, 2'b0, 5'd0, 0, 4'd0), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset RegWriteW", RegWriteW, 0);
    chk("reset RdataW", RdataW, 0);
    chk("reset ALUResultW", ALUResultW, 0);
    chk("reset PCPlus4W", PCPlus4W, 0);
    chk("reset RdW", RdW, 0);
    chk("reset ResultSrcW", ResultSrcW, 0);
    chk("reset StallM", StallM, 0);
    chk("reset req", bus.req, 0);
    chk("reset MisalignErr", MisalignErr, 0);
    chk("reset BusErr", BusErr, 0);
    reset = 1'b0;

    for (int i = 0; i < $size(vt); i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].be, vt[i].wd, vt[i].rdw, vt[i].mis);

    // Timeout: no rvalid ever; four stall cycles then a BusErr pulse with req dropped.
    drive(mkop(1, 0, 3'b010, 32'h700, 32'h0, 32'h0, 2'b01, 5'd4, 1, 4'd0), 32'h704);
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk($sformatf("tmo stall c%0d", c), StallM, 1);
      chk($sformatf("tmo req c%0d", c), bus.req, 1);
      chk($sformatf("tmo buserr c%0d", c), BusErr, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("tmo abort stall", StallM, 0);
    chk("tmo abort req", bus.req, 0);
    chk("tmo abort buserr", BusErr, 1);
    @(posedge clk);
    #1;
    chk("tmo bubble RegWriteW", RegWriteW, 0);
    // Stray rvalid while idle with no request must be ignored.
    drive(mkop(0, 0, 3'b000, 32'h77, 32'h0, 32'h0, 2'b00, 5'd2, 1, 4'd0), 32'h78);
    bus.rvalid = 1'b1;
    @(negedge clk);
    chk("idle rvalid buserr", BusErr, 0);
    chk("idle rvalid stall", StallM, 0);
    chk("idle rvalid req", bus.req, 0);
    @(posedge clk);
    #1;
    bus.rvalid = 1'b0;
    chk("idle rvalid ALUResultW", ALUResultW, 32'h77);
    chk("idle rvalid RegWriteW", RegWriteW, 1);
    // Counter must restart from zero: rvalid on the last possible cycle still completes.
    run_op("post-tmo LW", mkop(1, 0, 3'b010, 32'h710, 32'h0, 32'h5A5A5A5A, 2'b01, 5'd12, 1, 4'd4),
           4'hF, 32'h0, 32'h5A5A5A5A, 1'b0);

    // Reset while BUSY abandons the access.
    drive(mkop(1, 0, 3'b010, 32'h800, 32'h0, 32'h0, 2'b01, 5'd9, 1, 4'd0), 32'h804);
    @(negedge clk);
    chk("rstbusy stall0", StallM, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstbusy stall1", StallM, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstbusy RegWriteW", RegWriteW, 0);
    chk("rstbusy ALUResultW", ALUResultW, 0);
    chk("rstbusy PCPlus4W", PCPlus4W, 0);
    chk("rstbusy RdW", RdW, 0);
    run_op("rstbusy ALU", mkop(0, 0, 3'b000, 32'h55, 32'h0, 32'h0, 2'b00, 5'd3, 1, 4'd0),
           4'hF, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind    = int'($urandom_range(0, 2));
      o       = mkop(0, 0, 3'b0, $urandom, $urandom, $urandom, 2'b00,
                     5'($urandom_range(0, 31)), 1, 4'($urandom_range(0, TO)));
      o.rd_en = (kind == 1);
      o.wr_en = (kind == 2);
      if (kind == 1) begin
        tmp  = int'($urandom_range(0, 4));
        o.f3 = 3'((tmp < 3) ? tmp : tmp + 1);
        o.rsrc = 2'b01;
      end else if (kind == 2) begin
        o.f3   = 3'($urandom_range(0, 2));
        o.regw = 1'b0;
      end else begin
        o.f3   = 3'($urandom_range(0, 7));
        o.rsrc = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      end
      if ($urandom_range(0, 1) != 0) o.addr[1:0] = 2'b00;
      model(o, mbe, mwd, mrd, mmis);
      run_op($sformatf("rnd%0d", i), o, mbe, mwd, mrd, mmis);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage load/store unit and MEM/WB pipeline register for the 5-stage core.
- Drives the data-memory request/response bus for loads and stores. Aligns and sign- or zero-extends load data.
- Produces the registered W-stage bundle consumed by writeback: RegWriteW, ResultSrcW, ALUResultW, RdataW, RdW, PCPlus4W.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in BUSY without dmem_rvalid before the access is aborted with BusErr.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- RegWriteM  in  1  M-stage register-write enable
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4
- MemWriteM  in  1  store
- MemReadM  in  1  load
- Funct3M  in  3  access size/sign (RV32I load/store encoding)
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- PCPlus4M  in  32  PC+4
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rvalid  in  1  request accepted and completed (read data valid for loads)
- dmem_rdata  in  32  raw read word
- StallM  out  1  hold F/D/E/M stages
- MisalignErr  out  1  one-cycle pulse, misaligned access dropped
- BusErr  out  1  one-cycle pulse, access timed out
- RegWriteW, ResultSrcW[1:0], ALUResultW[31:0], RdataW[31:0], RdW[4:0], PCPlus4W[31:0]  out  W-stage registered bundle

Behaviour:
- Reset:
  - All W outputs 0, StallM 0, dmem_req 0, both error pulses 0.
  - FSM returns to IDLE and the counter clears.
  - Reset mid-transaction abandons the request; memory must tolerate a dropped req.
- MemOp = MemReadM | MemWriteM. MemReadM and MemWriteM both high is illegal; treat as a load.
- Misaligned access:
  - Halfword with ALUResultM[0]=1, or word with ALUResultM[1:0]!=0.
  - No dmem_req is issued. MisalignErr pulses for 1 cycle. The W bundle captures a bubble (RegWriteW=0). No stall.
- Store lanes: a = ALUResultM[1:0].
  - SB: be = 0001<<a, wdata = {4{WriteDataM[7:0]}}.
  - SH: be = 0011<<a, wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 1111, wdata = WriteDataM.
  - Loads: be = 1111, dmem_we = 0.
- FSM states IDLE and BUSY.
  - IDLE, aligned MemOp: dmem_req=1 combinationally from the M inputs.
    - If dmem_rvalid is also 1 in that cycle, the access completes with zero wait: no stall, W captures the result at the edge.
    - Otherwise StallM=1 and the FSM goes to BUSY.
  - BUSY: dmem_req, we, addr, wdata and be are held stable. Upstream guarantees the M inputs are stable while StallM=1. StallM=1.
    - Each cycle without rvalid, the counter increments and W captures a bubble (RegWriteW=0).
    - On dmem_rvalid: StallM=0, W captures the completed access, go to IDLE, clear the counter.
    - When the counter reaches TIMEOUT_CYCLES-1 without rvalid: drop req, pulse BusErr, capture a bubble, StallM=0, go to IDLE.
  - rvalid while IDLE with no request is ignored.
- Load alignment: from dmem_rdata and a.
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: halfword a[1], sign- or zero-extended.
  - LW: full word.
  - RdataW registers the aligned value. It is 0 for non-loads.
- W capture: on every non-stalled, non-error cycle, W registers copy the M inputs. Latency M->W is 1 cycle after completion.
- RegWriteW is forced 0 when RdM=0 (x0 writes suppressed).

Test Plan:
- Zero-wait LW: ALUResultM=0x100, MemReadM=1, ResultSrcM=01, RdM=5, rvalid same cycle, rdata=0xDEADBEEF -> no stall; next cycle RdataW=0xDEADBEEF, RdW=5, RegWriteW=1.
- 3-wait LB: addr 0x103, rdata=0x80FF1234 arriving 3 cycles late -> StallM high 3 cycles, req held constant, RdataW=0xFFFFFF80; the same case as LBU gives 0x00000080.
- SH: addr 0x202, WriteDataM=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, dmem_we=1.
- Misaligned LW at 0x101 -> dmem_req stays 0, MisalignErr 1-cycle pulse, RegWriteW=0 next cycle.
- Timeout with TIMEOUT_CYCLES=4 and no rvalid -> StallM high 4 cycles, then BusErr pulse, req drops, FSM in IDLE.
- Reset asserted in BUSY -> next edge: req=0, StallM=0, all W outputs 0; a following ALU op (ResultSrcM=00, ALUResultM=0x55, RdM=3) passes to W with 1-cycle latency.
